// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and its matching receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, line-level constants, frame length helper.
package serial_pkg;

  // Frame phases; encodings are shared with the receiver so state dumps line up.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } serial_state_t;

  // Level held on the line between frames (and used for the stop bit).
  localparam logic LINE_IDLE = 1'b1;
  // Level that marks the beginning of a frame.
  localparam logic START_BIT = 1'b0;

  // Clock cycles from the first start-bit cycle to the end of the stop bit.
  function automatic int frame_cycles(input int width, input int clks_per_bit);
    return (width + 2) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit slot.
// Latency: bit_end asserts on the CLKS_PER_BIT-th cycle after a clear.
// Backpressure: none; free-running, restarted by clear.
// Ports:
//   Clk     - system clock
//   Rst_n   - asynchronous active-low reset
//   clear   - restart the count at zero on the next edge
//   bit_end - high in the last cycle of the current bit slot
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // With CLKS_PER_BIT=1 the count never leaves zero, so bit_end is constantly high.
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, stop bit, on a registered line.
// Latency: start bit appears the cycle after Load is accepted; frame lasts (WIDTH+2)*CLKS_PER_BIT cycles.
// Backpressure: Load is accepted only while Ready is high; Load during a frame is dropped, not queued.
// Ports:
//   Clk, Rst_n - clock and asynchronous active-low reset
//   D, Load    - parallel word and load request (taken when Load && Ready)
//   Ready/Busy - idle-and-accepting / frame-in-progress (always complementary)
//   Tx         - registered serial line, idles high
//   Done       - one-cycle pulse in the first idle cycle after a stop bit
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Ready,
  output logic             Busy,
  output logic             Tx,
  output logic             Done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  serial_state_t    state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             timer_clear;

  // Every phase change (including load acceptance) starts a fresh bit slot.
  assign timer_clear = (state_d != state_q);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    tx_d    = LINE_IDLE;

    unique case (state_q)
      ST_IDLE: begin
        if (Load) begin
          shift_d = D;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line level is computed from the upcoming phase so Tx can be a plain
    // flop that changes on the same edge as the state.
    unique case (state_d)
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = LINE_IDLE;
    endcase
  end

  assign Ready = (state_q == ST_IDLE);
  assign Busy  = ~Ready;
  assign Tx    = tx_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: two instances (CLKS_PER_BIT=4 and =1) driven with
// directed and random frames; the expected line is taken from the frame bit list.
module tb_serial_tx;
  import serial_pkg::*;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] d_s     [2];
  logic       load_s  [2];
  logic       ready_s [2];
  logic       busy_s  [2];
  logic       tx_s    [2];
  logic       done_s  [2];

  int total = 0;
  int bad   = 0;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .D(d_s[0]), .Load(load_s[0]),
    .Ready(ready_s[0]), .Busy(busy_s[0]), .Tx(tx_s[0]), .Done(done_s[0])
  );

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .D(d_s[1]), .Load(load_s[1]),
    .Ready(ready_s[1]), .Busy(busy_s[1]), .Tx(tx_s[1]), .Done(done_s[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // Line level in cycle t (1-based) of a frame: slot 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic exp_line(input logic [7:0] data, input int t, input int c);
    logic [9:0] fr;
    fr = {1'b1, data, 1'b0};
    fr = fr >> ((t - 1) / c);
    return fr[0];
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      for (int j = 0; j < 2; j++) begin
        chk("idle_tx", tx_s[j], 1'b1);
        chk("idle_ready", ready_s[j], 1'b1);
        chk("idle_busy", busy_s[j], 1'b0);
        chk("idle_done", done_s[j], 1'b0);
      end
    end
  endtask

  // Caller has already driven D=data and Load=1 on instance inst.
  // hold: keep Load high and switch D to nxt (back-to-back).
  // poke: frame cycle at which a spurious Load with D=FF is pulsed (0 = none).
  task automatic frame(input int inst, input logic [7:0] data, input bit hold,
                       input logic [7:0] nxt, input int poke);
    int c;
    int f;
    c = (inst == 0) ? 4 : 1;
    f = frame_cycles(8, c);
    @(posedge Clk);
    for (int t = 1; t <= f; t++) begin
      @(negedge Clk);
      chk("frame_tx", tx_s[inst], exp_line(data, t, c));
      chk("frame_ready", ready_s[inst], 1'b0);
      chk("frame_busy", busy_s[inst], 1'b1);
      chk("frame_done", done_s[inst], 1'b0);
      if (t == 1) begin
        if (hold) d_s[inst] = nxt;
        else begin
          load_s[inst] = 1'b0;
          d_s[inst]    = 8'($urandom);
        end
      end
      if (poke != 0 && t == poke) begin
        load_s[inst] = 1'b1;
        d_s[inst]    = 8'hFF;
      end
      if (poke != 0 && t == poke + 1) load_s[inst] = 1'b0;
    end
    @(negedge Clk);
    chk("end_done", done_s[inst], 1'b1);
    chk("end_ready", ready_s[inst], 1'b1);
    chk("end_busy", busy_s[inst], 1'b0);
    chk("end_tx", tx_s[inst], 1'b1);
  endtask

  initial begin
    int inst;
    logic [7:0] data;

    Rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      load_s[j] = 1'b0;
      d_s[j]    = 8'h00;
    end

    // Reset held for three cycles, then ten idle cycles.
    repeat (3) begin
      @(negedge Clk);
      for (int j = 0; j < 2; j++) begin
        chk("rst_tx", tx_s[j], 1'b1);
        chk("rst_ready", ready_s[j], 1'b1);
        chk("rst_busy", busy_s[j], 1'b0);
        chk("rst_done", done_s[j], 1'b0);
      end
    end
    Rst_n = 1'b1;
    idle_check(10);

    // Basic frame A5.
    d_s[0] = 8'hA5; load_s[0] = 1'b1;
    frame(0, 8'hA5, 1'b0, 8'h00, 0);
    idle_check(3);

    // Load pulsed with FF during the data phase is ignored.
    d_s[0] = 8'h3C; load_s[0] = 1'b1;
    frame(0, 8'h3C, 1'b0, 8'h00, 22);
    idle_check(5);

    // Back-to-back with Load held: exactly one idle cycle (the Done cycle) between frames.
    d_s[0] = 8'h01; load_s[0] = 1'b1;
    frame(0, 8'h01, 1'b1, 8'h80, 0);
    frame(0, 8'h80, 1'b0, 8'h00, 0);
    idle_check(3);

    // Reset during data bit 3 of F0.
    d_s[0] = 8'hF0; load_s[0] = 1'b1;
    @(posedge Clk);
    for (int t = 1; t <= 18; t++) begin
      @(negedge Clk);
      chk("pre_rst_tx", tx_s[0], exp_line(8'hF0, t, 4));
      if (t == 1) load_s[0] = 1'b0;
    end
    #2 Rst_n = 1'b0;
    #1;
    chk("async_tx", tx_s[0], 1'b1);
    chk("async_ready", ready_s[0], 1'b1);
    chk("async_busy", busy_s[0], 1'b0);
    chk("async_done", done_s[0], 1'b0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    idle_check(6);
    d_s[0] = 8'h55; load_s[0] = 1'b1;
    frame(0, 8'h55, 1'b0, 8'h00, 0);
    idle_check(2);

    // One clock per bit.
    d_s[1] = 8'hC3; load_s[1] = 1'b1;
    frame(1, 8'hC3, 1'b0, 8'h00, 0);
    idle_check(3);

    // Random words on random instances.
    for (int n = 0; n < 10; n++) begin
      inst = $urandom_range(0, 1);
      data = 8'($urandom);
      d_s[inst] = data; load_s[inst] = 1'b1;
      frame(inst, data, 1'b0, 8'h00, 0);
      idle_check($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Serial transmitter: accepts a parallel word on a load handshake and shifts it out on a single registered line. Frame format is 1 start bit (0), WIDTH data bits LSB first, and 1 stop bit (1). Line idles high. It is the driving end of the single-bit serial links that the team's latch/register capture blocks sample on the receive side.

Parameters:
WIDTH, 8, data bits per frame (1..16)
CLKS_PER_BIT, 4, Clk cycles per transmitted bit (>=1); bit counter width $clog2(CLKS_PER_BIT+1)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst_n  input  1  asynchronous active-low reset
D  input  WIDTH  parallel data word, sampled only at load acceptance
Load  input  1  load request; accepted when Load && Ready at a rising edge
Ready  output  1  high when idle and able to accept Load
Busy  output  1  high while a frame (start/data/stop) is on the line
Tx  output  1  serial line, registered
Done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Reset (Rst_n low, async): state IDLE; Tx=1, Ready=1, Busy=0, Done=0; shift register, bit index and cycle counter cleared. Reset mid-frame aborts immediately. Tx goes high asynchronously and no Done is issued.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: Tx=1, Ready=1, Busy=0. On edge k with Load=1, D is copied into the shift register. State becomes START; Ready=0 and Busy=1 from cycle k+1.
- START: Tx=0 for exactly CLKS_PER_BIT cycles (k+1 .. k+C). Then go to DATA with bit index 0.
- DATA: Tx = shift register bit 0 for CLKS_PER_BIT cycles, then shift right and increment the index. After bit WIDTH-1 completes, go to STOP. Data bit i occupies cycles k+1+(i+1)C .. k+(i+2)C.
- STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- First IDLE cycle after STOP: Done=1 for exactly one cycle, and Ready=1 in that same cycle.
- Frame length: (WIDTH+2)*CLKS_PER_BIT cycles from k+1 to the end of the stop bit.
- Load while Ready=0 is ignored; no queuing. D changes after acceptance do not affect the frame in progress.
- Back-to-back: a Load held high is accepted in the Done cycle. The next start bit begins on the following cycle, so there is exactly one idle-high cycle between frames.
- CLKS_PER_BIT=1: every bit lasts one cycle and the cycle counter is unused. Behaviour is otherwise identical.
- Busy is the inverse of Ready at all times outside reset. Tx is never combinationally derived from inputs.

Decomposition:
- Shared package serial_pkg: state encoding localparams (ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3), line-level constants LINE_IDLE=1'b1 and START_BIT=1'b0. The matching receiver uses the same package.
- One sub-module, bit_timer: cycle counter parameterised by CLKS_PER_BIT.
  - Inputs: Clk, Rst_n, clear.
  - Output: bit_end pulse when the count reaches CLKS_PER_BIT-1.
  - serial_tx clears it on load acceptance and on every state change.

Test Plan:
- Reset then idle: hold Rst_n=0 for 3 cycles, release, Load=0 for 10 cycles -> Tx=1, Ready=1, Busy=0, Done=0 throughout.
- Basic frame: WIDTH=8, C=4, D=8'hA5 with Load accepted at edge k -> Tx sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1. Done pulses at cycle k+41 with Ready=1.
- Load while busy: accept 8'h3C, then pulse Load with D=8'hFF during the DATA state -> serial output is still 0x3C, only one Done is issued, and Ready stays 0 until frame end.
- Back-to-back: Load held high with D=8'h01 then 8'h80 -> the second start bit begins exactly one idle-high cycle after the first stop bit. Two Done pulses are 41 cycles apart.
- Reset mid-frame: drop Rst_n during data bit 3 of 8'hF0 -> Tx=1 immediately (async), Ready=1 after release, no Done. A new Load of 8'h55 then transmits a correct frame.
- CLKS_PER_BIT=1, D=8'hC3 -> 10-cycle frame 0,1,1,0,0,0,0,1,1,1. Done at k+11.
